// File: rtl/sump_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : sump_cmd_rx
// Purpose  : Frames SUMP short (1-byte) and long (5-byte) commands from the
//            link-layer byte stream and presents opcode/config_data/execute
//            to the analyzer core. An inter-byte timeout abandons truncated
//            long commands so the host can always resynchronise.
// Revision : 1.0 - initial release
// ============================================================================
module sump_cmd_rx #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [7:0]  opcode,
  output logic [31:0] config_data,
  output logic        execute,
  output logic        cmd_error,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_expire = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG  = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [7:0]       pend_op_q,   pend_op_d;
  logic [31:0]      shadow_q,    shadow_d;
  logic [1:0]       idx_q,       idx_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [7:0]       opcode_q,    opcode_d;
  logic [31:0]      config_q,    config_d;
  logic             execute_q,   execute_d;
  logic             cmd_error_q, cmd_error_d;
  logic             busy_q,      busy_d;
  logic             rx_ready_q,  rx_ready_d;

  logic             w_accept;

  assign w_accept = rx_valid && rx_ready_q;

  // Next-state and output computation; visible outputs only move on entry to EXEC.
  always_comb begin
    state_d     = state_q;
    pend_op_d   = pend_op_q;
    shadow_d    = shadow_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    config_d    = config_q;
    cmd_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (w_accept) begin
          if (!rx_data[7]) begin
            opcode_d = rx_data;
            config_d = 32'h0;
            state_d  = ST_EXEC;
          end else begin
            pend_op_d = rx_data;
            shadow_d  = 32'h0;
            idx_d     = 2'd0;
            state_d   = ST_ARG;
          end
        end
      end

      ST_ARG: begin
        if (w_accept) begin
          // A byte on the expiry cycle wins over the timeout.
          shadow_d[{idx_q, 3'b000} +: 8] = rx_data;
          idx_d = idx_q + 2'd1;
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            opcode_d = pend_op_q;
            config_d = {rx_data, shadow_q[23:0]};
            state_d  = ST_EXEC;
          end
        end else if (cnt_q == c_cnt_expire) begin
          cnt_d       = '0;
          cmd_error_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (cnt_q < c_cnt_expire) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_EXEC: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    execute_d  = (state_d == ST_EXEC);
    busy_d     = (state_d == ST_ARG);
    rx_ready_d = (state_d != ST_EXEC);
  end

  // State and registered outputs; async reset discards any partial frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pend_op_q   <= 8'h0;
      shadow_q    <= 32'h0;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      opcode_q    <= 8'h0;
      config_q    <= 32'h0;
      execute_q   <= 1'b0;
      cmd_error_q <= 1'b0;
      busy_q      <= 1'b0;
      rx_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_op_q   <= pend_op_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      config_q    <= config_d;
      execute_q   <= execute_d;
      cmd_error_q <= cmd_error_d;
      busy_q      <= busy_d;
      rx_ready_q  <= rx_ready_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign opcode      = opcode_q;
  assign config_data = config_q;
  assign execute     = execute_q;
  assign cmd_error   = cmd_error_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sump_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sump_cmd_rx
// Purpose  : Scoreboard bench for sump_cmd_rx: directed and random byte
//            streams against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sump_cmd_rx;

  localparam int TO = 16;

  logic        clock    = 1'b0;
  logic        reset_n  = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h0;
  logic        rx_ready;
  logic [7:0]  opcode;
  logic [31:0] config_data;
  logic        execute;
  logic        cmd_error;
  logic        busy;

  sump_cmd_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .opcode      (opcode),
    .config_data (config_data),
    .execute     (execute),
    .cmd_error   (cmd_error),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        err;
    int          cyc;
    logic [7:0]  op;
    logic [31:0] cfg;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] frame[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_acc = 0;
  logic       rdy_m = 1'b1;
  logic       acc_m = 1'b0;
  logic [7:0] vis_op = 8'h0;
  logic [31:0] vis_cfg = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: bytes gathered into frames; a frame closes on its 5th
  // byte, or is abandoned TO edges after its last accepted byte.
  always @(posedge clock) begin
    logic done;
    ev_t  e;
    done = 1'b0;
    e    = '{1'b0, 0, 8'h0, 32'h0};
    cyc++;
    if (!reset_n) begin
      frame.delete();
      rdy_m   = 1'b1;
      acc_m   = 1'b0;
      vis_op  = 8'h0;
      vis_cfg = 32'h0;
    end else begin
      acc_m = rx_valid && rdy_m;
      if (acc_m) begin
        last_acc = cyc;
        if (frame.size() == 0 && !rx_data[7]) begin
          e    = '{1'b0, cyc, rx_data, 32'h0};
          done = 1'b1;
        end else begin
          frame.push_back(rx_data);
          if (frame.size() == 5) begin
            e    = '{1'b0, cyc, frame[0], {frame[4], frame[3], frame[2], frame[1]}};
            done = 1'b1;
            frame.delete();
          end
        end
      end else if (frame.size() > 0 && (cyc - last_acc) == TO) begin
        frame.delete();
        exp_q.push_back('{1'b1, cyc, vis_op, vis_cfg});
      end
      if (done) begin
        vis_op  = e.op;
        vis_cfg = e.cfg;
        exp_q.push_back(e);
      end
      rdy_m = !done;
    end
  end

  // Monitor: level checks every cycle, pulses popped from the scoreboard.
  always @(negedge clock) begin
    ev_t e;
    if (reset_n) begin
      chk("rx_ready", rx_ready, rdy_m);
      chk("busy", busy, frame.size() > 0);
      chk("opcode", opcode, vis_op);
      chk("config_data", config_data, vis_cfg);
      if (execute || cmd_error) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: execute=%b cmd_error=%b, none expected (cycle %0d)",
                   execute, cmd_error, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_cmd_error", cmd_error, e.err);
          chk("pulse_execute", execute, !e.err);
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_opcode", opcode, e.op);
          chk("pulse_config", config_data, e.cfg);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk(e.err ? "missing_cmd_error" : "missing_execute", {execute, cmd_error}, e.err ? 2'b01 : 2'b10);
      end
    end
  end

  // Present a byte after 'gap' idle cycles and hold it until accepted.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(posedge clock);
    if (gap > 0) #1;
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!acc_m && n < 8);
    if (!acc_m) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: byte %0h not accepted after %0d cycles, required within 2", b, n);
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic check_reset_values();
    chk("rst_opcode", opcode, 8'h0);
    chk("rst_config", config_data, 32'h0);
    chk("rst_execute", execute, 1'b0);
    chk("rst_cmd_error", cmd_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int g;
    // Power-on reset
    repeat (3) @(posedge clock);
    #1;
    check_reset_values();
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Short command
    send(8'h02, 0);
    // Long command, consecutive bytes
    send(8'hC0, 2); send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 0);
    // Reset mid-frame: outputs clear at once, no pulses
    send(8'hC2, 3); send(8'h01, 0);
    #2 reset_n = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    send(8'h05, 1);
    // Back-to-back: byte held through EXEC
    send(8'h80, 2); send(8'h01, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h01, 0);
    // Timeout then recovery
    send(8'h81, 2); send(8'hAA, 0);
    send(8'h00, 20);
    // Race: every argument byte lands on the expiry cycle
    send(8'h83, 2); send(8'h11, TO - 1); send(8'h22, TO - 1); send(8'h33, TO - 1); send(8'h44, TO - 1);
    // One cycle late: timeout fires, late byte starts a new command
    send(8'h85, 2); send(8'h01, TO);
    // Resync with five zeros mid-frame
    send(8'hC1, 2); send(8'h11, 0);
    for (int i = 0; i < 5; i++) send(8'h00, 0);

    // Random traffic with occasional long gaps around the timeout
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)       g = 0;
      else if (r < 8)  g = int'($urandom_range(1, 4));
      else if (r == 8) g = int'($urandom_range(TO - 2, TO));
      else             g = int'($urandom_range(TO + 1, TO + 4));
      send(8'($urandom), g);
    end

    repeat (TO + 20) @(posedge clock);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
